// File: rtl/branch_predict_bht_pkg.sv
// Shared decode constants and helpers for the branch history table predictor.
// Opcode and REGIMM rt values are the ones the rest of the core decodes from.
package branch_predict_bht_pkg;

  localparam int INST_BUS_W = 32;
  localparam logic RstEnable = 1'b1;
  localparam logic BP_YES = 1'b1;
  localparam logic BP_NO  = 1'b0;

  localparam logic [5:0] EXE_BEQ         = 6'b000100;
  localparam logic [5:0] EXE_BNE         = 6'b000101;
  localparam logic [5:0] EXE_BLEZ        = 6'b000110;
  localparam logic [5:0] EXE_BGTZ        = 6'b000111;
  localparam logic [5:0] EXE_REGIMM_INST = 6'b000001;

  localparam logic [4:0] EXE_BLTZ   = 5'b00000;
  localparam logic [4:0] EXE_BGEZ   = 5'b00001;
  localparam logic [4:0] EXE_BLTZAL = 5'b10000;
  localparam logic [4:0] EXE_BGEZAL = 5'b10001;

  localparam logic [1:0] BP_CNT_STRONG_NO  = 2'b00;
  localparam logic [1:0] BP_CNT_WEAK_NO    = 2'b01;
  localparam logic [1:0] BP_CNT_WEAK_YES   = 2'b10;
  localparam logic [1:0] BP_CNT_STRONG_YES = 2'b11;

  typedef enum logic [1:0] {
    BR_NONE,
    BR_CMP,
    BR_REGIMM
  } br_class_e;

  function automatic br_class_e classify(input logic [5:0] op, input logic [4:0] rt);
    br_class_e cls;
    cls = BR_NONE;
    case (op)
      EXE_BEQ, EXE_BNE, EXE_BLEZ, EXE_BGTZ: cls = BR_CMP;
      EXE_REGIMM_INST: begin
        case (rt)
          EXE_BLTZ, EXE_BGEZ, EXE_BLTZAL, EXE_BGEZAL: cls = BR_REGIMM;
          default: cls = BR_NONE;
        endcase
      end
      default: cls = BR_NONE;
    endcase
    return cls;
  endfunction

  function automatic logic is_cond_branch(input logic [5:0] op, input logic [4:0] rt);
    return classify(op, rt) != BR_NONE;
  endfunction

  // Word offset: sign-extended imm16 shifted left by two, relative to the delay slot.
  function automatic logic [INST_BUS_W-1:0] branch_target(input logic [INST_BUS_W-1:0] pc,
                                                          input logic [15:0] imm);
    logic [INST_BUS_W-1:0] off;
    off = {{14{imm[15]}}, imm, 2'b00};
    return pc + 32'd4 + off;
  endfunction

endpackage

// File: rtl/branch_predict_bht_if.sv
// Fetch-side prediction and EX-side resolution signals of the branch predictor.
// master = pipeline side, slave = predictor.
interface branch_predict_bht_if #(
  parameter int INDEX_BITS = 6
);

  logic [31:0]           pc;
  logic [31:0]           inst;
  logic                  branch_predict;
  logic [31:0]           branch_predict_addr;
  logic [INDEX_BITS-1:0] pred_index;
  logic                  upd_valid;
  logic [INDEX_BITS-1:0] upd_index;
  logic                  upd_taken;

  modport master (
    output pc, inst, upd_valid, upd_index, upd_taken,
    input  branch_predict, branch_predict_addr, pred_index
  );

  modport slave (
    input  pc, inst, upd_valid, upd_index, upd_taken,
    output branch_predict, branch_predict_addr, pred_index
  );

endinterface

// File: rtl/branch_predict_bht_sat_counter.sv
// Next-state function of one CNT_BITS-wide saturating up/down counter.
// Counts toward all-ones on taken and toward zero on not-taken, never wrapping.
module bp_sat_counter #(
  parameter int CNT_BITS = 2
) (
  input  logic [CNT_BITS-1:0] cnt_i,
  input  logic                taken_i,
  output logic [CNT_BITS-1:0] cnt_o
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_MIN = '0;

  function automatic logic [CNT_BITS-1:0] sat_step(input logic [CNT_BITS-1:0] cnt,
                                                   input logic                taken);
    logic [CNT_BITS-1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != CNT_MAX) nxt = cnt + 1'b1;
    end else begin
      if (cnt != CNT_MIN) nxt = cnt - 1'b1;
    end
    return nxt;
  endfunction

  assign cnt_o = sat_step(cnt_i, taken_i);

endmodule

// File: rtl/branch_predict_bht.sv
// Table of saturating counters giving a zero-latency taken/not-taken prediction,
// indexed by PC or PC xor global history, trained by resolutions from EX.
module branch_predict_bht #(
  parameter int INDEX_BITS = 6,
  parameter int CNT_BITS   = 2,
  parameter int INIT_CNT   = 2 ** (CNT_BITS - 1) - 1,
  parameter bit GSHARE     = 1'b0,
  parameter int GHR_BITS   = INDEX_BITS
) (
  input logic                clk,
  input logic                rst,
  branch_predict_bht_if.slave bus
);

  import branch_predict_bht_pkg::*;

  localparam int                  TABLE_SIZE = 2 ** INDEX_BITS;
  localparam logic [CNT_BITS-1:0] INIT_VAL   = CNT_BITS'(INIT_CNT);

  if (GHR_BITS > INDEX_BITS || GHR_BITS < 1 || CNT_BITS < 2 || CNT_BITS > 4 ||
      INIT_CNT < 0 || INIT_CNT >= 2 ** CNT_BITS) begin : g_cfg_err
    $error("branch_predict_bht: unsupported INDEX_BITS/CNT_BITS/INIT_CNT/GHR_BITS combination");
  end

  logic [CNT_BITS-1:0]   cnt_q [TABLE_SIZE];
  logic [CNT_BITS-1:0]   cnt_d;
  logic [INDEX_BITS-1:0] ghr_ext;
  logic [INDEX_BITS-1:0] pred_idx;
  logic                  is_branch;
  logic                  unused_rs;

  // History only advances on resolved branches, so flushes never need repair.
  if (GSHARE) begin : g_ghr
    logic [GHR_BITS-1:0] ghr_q;
    logic [GHR_BITS-1:0] ghr_d;

    if (GHR_BITS == 1) begin : g_one
      assign ghr_d = bus.upd_taken;
    end else begin : g_many
      assign ghr_d = {ghr_q[GHR_BITS-2:0], bus.upd_taken};
    end

    always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
        ghr_q <= '0;
      end else if (bus.upd_valid) begin
        ghr_q <= ghr_d;
      end
    end

    assign ghr_ext = INDEX_BITS'(ghr_q);
  end else begin : g_no_ghr
    assign ghr_ext = '0;
  end

  bp_sat_counter #(
    .CNT_BITS(CNT_BITS)
  ) u_sat (
    .cnt_i  (cnt_q[bus.upd_index]),
    .taken_i(bus.upd_taken),
    .cnt_o  (cnt_d)
  );

  // Reset wins over a coincident update; only the addressed entry is written.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < TABLE_SIZE; i++) begin
        cnt_q[i] <= INIT_VAL;
      end
    end else if (bus.upd_valid) begin
      cnt_q[bus.upd_index] <= cnt_d;
    end
  end

  // Read is asynchronous and sees the table before this cycle's write.
  assign pred_idx  = bus.pc[INDEX_BITS+1:2] ^ ghr_ext;
  assign is_branch = is_cond_branch(bus.inst[31:26], bus.inst[20:16]);

  assign bus.pred_index          = pred_idx;
  assign bus.branch_predict      = is_branch ? cnt_q[pred_idx][CNT_BITS-1] : BP_NO;
  assign bus.branch_predict_addr = branch_target(bus.pc, bus.inst[15:0]);

  assign unused_rs = ^bus.inst[25:21];

endmodule

// File: tb/tb_branch_predict_bht.sv
// Directed bench for branch_predict_bht: a PC-indexed instance and a gshare
// instance with a 2-bit history share one clock and reset.
module tb_branch_predict_bht;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  branch_predict_bht_if #(.INDEX_BITS(6)) bus0 ();
  branch_predict_bht_if #(.INDEX_BITS(6)) bus1 ();

  branch_predict_bht #(
    .INDEX_BITS(6), .CNT_BITS(2), .INIT_CNT(1), .GSHARE(1'b0), .GHR_BITS(6)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  branch_predict_bht #(
    .INDEX_BITS(6), .CNT_BITS(2), .INIT_CNT(1), .GSHARE(1'b1), .GHR_BITS(2)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] BEQ_4 = 32'h1022_0004;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd0(input logic v, input logic [5:0] idx, input logic tk);
    bus0.upd_valid = v;
    bus0.upd_index = idx;
    bus0.upd_taken = tk;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus0.pc = 32'h0040_0010;
    bus0.inst = BEQ_4;
    bus1.pc = 32'h0000_0010;
    bus1.inst = BEQ_4;
    #1;
    checks++;
    if (bus0.branch_predict !== 1'b0) begin
      failures++; $display("FAIL reset_bp got=%0b exp=0", bus0.branch_predict);
    end
    checks++;
    if (bus0.branch_predict_addr !== 32'h0040_0024) begin
      failures++; $display("FAIL reset_addr got=%h exp=00400024", bus0.branch_predict_addr);
    end
    checks++;
    if (bus0.pred_index !== 6'd4) begin
      failures++; $display("FAIL reset_idx got=%0d exp=4", bus0.pred_index);
    end
    checks++;
    if (bus1.pred_index !== 6'd4) begin
      failures++; $display("FAIL reset_gshare_idx got=%0d exp=4", bus1.pred_index);
    end
  endtask

  // Counter at index 4: 01 -> 10 -> 11 -> 11 over three back-to-back taken updates.
  task automatic test_training();
    upd0(1'b1, 6'd4, 1'b1);
    step();
    checks++;
    if (bus0.branch_predict !== 1'b1) begin
      failures++; $display("FAIL train_1 got=%0b exp=1", bus0.branch_predict);
    end
    step();
    checks++;
    if (bus0.branch_predict !== 1'b1) begin
      failures++; $display("FAIL train_2 got=%0b exp=1", bus0.branch_predict);
    end
    step();
    upd0(1'b0, 6'd4, 1'b0);
    #1;
    checks++;
    if (bus0.branch_predict !== 1'b1) begin
      failures++; $display("FAIL train_sat got=%0b exp=1", bus0.branch_predict);
    end
  endtask

  // 11 -> 10 -> 01 -> 00 -> 00, then one taken brings it to 01 (not 11 from a wrap).
  task automatic test_untraining();
    upd0(1'b1, 6'd4, 1'b0);
    step();
    checks++;
    if (bus0.branch_predict !== 1'b1) begin
      failures++; $display("FAIL untrain_1 got=%0b exp=1", bus0.branch_predict);
    end
    step();
    checks++;
    if (bus0.branch_predict !== 1'b0) begin
      failures++; $display("FAIL untrain_2 got=%0b exp=0", bus0.branch_predict);
    end
    step();
    step();
    bus0.upd_taken = 1'b1;
    step();
    upd0(1'b0, 6'd4, 1'b0);
    #1;
    checks++;
    if (bus0.branch_predict !== 1'b0) begin
      failures++; $display("FAIL untrain_floor got=%0b exp=0", bus0.branch_predict);
    end
  endtask

  task automatic test_same_cycle();
    upd0(1'b1, 6'd4, 1'b1);
    #1;
    checks++;
    if (bus0.branch_predict !== 1'b0) begin
      failures++; $display("FAIL nobypass got=%0b exp=0", bus0.branch_predict);
    end
    step();
    upd0(1'b0, 6'd4, 1'b0);
    #1;
    checks++;
    if (bus0.branch_predict !== 1'b1) begin
      failures++; $display("FAIL visible_next got=%0b exp=1", bus0.branch_predict);
    end
    rst = 1'b1;
    upd0(1'b1, 6'd4, 1'b1);
    step();
    rst = 1'b0;
    upd0(1'b0, 6'd4, 1'b0);
    #1;
    checks++;
    if (bus0.branch_predict !== 1'b0) begin
      failures++; $display("FAIL rst_prio got=%0b exp=0", bus0.branch_predict);
    end
    upd0(1'b1, 6'd4, 1'b1);
    step();
    upd0(1'b0, 6'd4, 1'b0);
    #1;
    checks++;
    if (bus0.branch_predict !== 1'b1) begin
      failures++; $display("FAIL rst_to_weak_no got=%0b exp=1", bus0.branch_predict);
    end
  endtask

  // Index 4 holds 10, index 0 holds 01, index 63 holds 01.
  task automatic test_decode_target();
    logic [31:0] v_pc   [12];
    logic [31:0] v_inst [12];
    logic        v_bp   [12];
    logic [31:0] v_addr [12];
    v_pc = '{32'h0040_0010, 32'h0000_1000, 32'h0040_0010, 32'h0040_0010,
             32'h0040_0010, 32'h0040_0010, 32'h0040_0010, 32'h0040_0010,
             32'h0040_0010, 32'h0040_0010, 32'h0040_0010, 32'hFFFF_FFFC};
    v_inst = '{32'h0022_1821, 32'h1422_FFFF, 32'h0430_0008, 32'h0422_0008,
               32'h1C20_0008, 32'h1820_0008, 32'h0421_0008, 32'h0431_0008,
               32'h0420_0008, 32'h1022_8000, 32'h0810_0004, 32'h1022_0000};
    v_bp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    v_addr = '{32'h0040_6098, 32'h0000_1000, 32'h0040_0034, 32'h0040_0034,
               32'h0040_0034, 32'h0040_0034, 32'h0040_0034, 32'h0040_0034,
               32'h0040_0034, 32'h003E_0014, 32'h0040_0024, 32'h0000_0000};
    for (int i = 0; i < 12; i++) begin
      bus0.pc = v_pc[i];
      bus0.inst = v_inst[i];
      #1;
      checks++;
      if (bus0.branch_predict !== v_bp[i]) begin
        failures++;
        $display("FAIL decode_bp[%0d] inst=%h got=%0b exp=%0b", i, v_inst[i], bus0.branch_predict, v_bp[i]);
      end
      checks++;
      if (bus0.branch_predict_addr !== v_addr[i]) begin
        failures++;
        $display("FAIL target[%0d] inst=%h got=%h exp=%h", i, v_inst[i], bus0.branch_predict_addr, v_addr[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    upd0(1'b1, 6'd63, 1'b1);
    step();
    step();
    upd0(1'b0, 6'd0, 1'b0);
    bus0.inst = BEQ_4;
    bus0.pc = 32'h0000_00FC;
    #1;
    checks++;
    if (bus0.branch_predict !== 1'b1 || bus0.pred_index !== 6'd63) begin
      failures++; $display("FAIL idx63 got=%0b/%0d exp=1/63", bus0.branch_predict, bus0.pred_index);
    end
    bus0.pc = 32'h0000_00F8;
    #1;
    checks++;
    if (bus0.branch_predict !== 1'b0) begin
      failures++; $display("FAIL idx62_untouched got=%0b exp=0", bus0.branch_predict);
    end
    bus0.pc = 32'h0040_0010;
    #1;
    checks++;
    if (bus0.branch_predict !== 1'b1) begin
      failures++; $display("FAIL idx4_untouched got=%0b exp=1", bus0.branch_predict);
    end
  endtask

  task automatic test_gshare();
    bus1.upd_valid = 1'b1;
    bus1.upd_index = 6'd0;
    bus1.upd_taken = 1'b1;
    step();
    step();
    bus1.upd_valid = 1'b0;
    #1;
    checks++;
    if (bus1.pred_index !== 6'd7) begin
      failures++; $display("FAIL gshare_tt got=%0d exp=7", bus1.pred_index);
    end
    bus1.upd_valid = 1'b1;
    bus1.upd_taken = 1'b0;
    step();
    bus1.upd_valid = 1'b0;
    #1;
    checks++;
    if (bus1.pred_index !== 6'd6 || bus1.branch_predict !== 1'b0) begin
      failures++; $display("FAIL gshare_shift got=%0d/%0b exp=6/0", bus1.pred_index, bus1.branch_predict);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (bus1.pred_index !== 6'd4) begin
      failures++; $display("FAIL gshare_reset got=%0d exp=4", bus1.pred_index);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus0.pc = '0;
    bus0.inst = '0;
    upd0(1'b0, 6'd0, 1'b0);
    bus1.pc = '0;
    bus1.inst = '0;
    bus1.upd_valid = 1'b0;
    bus1.upd_index = '0;
    bus1.upd_taken = 1'b0;
    step();
    test_reset();
    test_training();
    test_untraining();
    test_same_cycle();
    test_decode_target();
    test_back_to_back();
    test_gshare();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predict_bht.md
Name: branch_predict_bht

Overview:
- Parametrised successor to the single-counter branch predictor.
- Holds a table of 2^INDEX_BITS saturating counters of CNT_BITS each, indexed by PC, or by PC xor global history when GSHARE=1.
- Sits beside the IF/ID stage:
  - gives a combinational taken/not-taken prediction and target for conditional branches;
  - takes a resolution update from EX one or more cycles later.

Parameters:
- INDEX_BITS, 6: table has 2^INDEX_BITS entries; index taken from pc[INDEX_BITS+1:2].
- CNT_BITS, 2: counter width, range 2..4. Predict taken = counter MSB.
- INIT_CNT, 2^(CNT_BITS-1)-1: reset value of every counter (weak not-taken).
- GSHARE, 0: 0 = index is the PC bits; 1 = index is PC bits xor GHR.
- GHR_BITS, INDEX_BITS: global history length. Must be ≤ INDEX_BITS; zero-extended for the xor.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  32  fetch address of inst.
- inst  in  32  instruction word at pc.
- branch_predict  out  1  1 = predict taken. Only ever 1 for beq/bne/bgtz/blez/bgez/bgezal/bltz/bltzal.
- branch_predict_addr  out  32  pc + 4 + (sign-extended imm16 << 2), modulo 2^32.
- pred_index  out  INDEX_BITS  index used for this prediction; the pipeline carries it to EX.
- upd_valid  in  1  a conditional branch has resolved this cycle.
- upd_index  in  INDEX_BITS  pred_index returned with that branch.
- upd_taken  in  1  actual branch outcome.

Behaviour:
- Decode:
  - Opcodes and REGIMM rt codes decoded from the shared constants.
  - Non-branch inst: branch_predict = 0; pred_index and branch_predict_addr are still driven.
- Prediction path:
  - Purely combinational from pc, inst, the table and GHR. Zero latency.
  - Table read is pre-update: a same-cycle upd_valid to the same index is not bypassed and becomes visible the next cycle.
- Index:
  - GSHARE=0: idx = pc[INDEX_BITS+1:2].
  - GSHARE=1: idx = pc[INDEX_BITS+1:2] ^ {zeros, ghr}.
- Counter update, on a clock edge with upd_valid=1 and rst=0:
  - upd_taken=1: cnt[upd_index] <= cnt + 1, saturating at 2^CNT_BITS-1.
  - upd_taken=0: cnt <= cnt - 1, saturating at 0.
  - Only the addressed entry changes.
- GHR:
  - Exists only when GSHARE=1; otherwise it is constant 0.
  - On upd_valid: ghr <= {ghr[GHR_BITS-2:0], upd_taken}.
  - Non-speculative, updated at resolution only, so a pipeline flush needs no repair.
- Reset:
  - rst=1 at an edge: all counters <= INIT_CNT and ghr <= 0.
  - rst has priority over a simultaneous upd_valid, which is dropped.
  - Reset mid-operation discards all learned state.
- Outputs during rst:
  - Remain combinational from current state.
  - branch_predict for a branch after reset = INIT_CNT MSB = 0 with defaults.
- Back-to-back updates to the same index on consecutive cycles each apply; there is no write coalescing.
- upd_valid with an index never predicted is still applied. The block does not check indices.
- Outside its stated range: GHR_BITS > INDEX_BITS or CNT_BITS < 2 is a configuration error and must fail at elaboration.

Decomposition:
- Shared constants file (existing consts.vh):
  - EXE_BEQ/BNE/BGTZ/BLEZ/REGIMM_INST and REGIMM rt codes;
  - BP_YES/BP_NO, InstBus, RstEnable.
- New constants: BP_CNT_STRONG_NO, BP_CNT_WEAK_NO, BP_CNT_WEAK_YES, BP_CNT_STRONG_YES for the 2-bit case.
- One natural sub-module: bp_sat_counter, the CNT_BITS saturating up/down next-state function.
  - Instantiated once on the update path.
  - Inputs: cnt, taken. Output: next value.
- Table is a register array with a single write port and a single combinational read port. It is not BRAM, since the read is asynchronous.

Test Plan:
- Reset behaviour: rst=1 for 1 cycle, then beq at pc=0x00400010 with imm=0x0004.
  - Expect branch_predict=0 and addr=0x00400024.
  - Expect pred_index=4 (defaults, GSHARE=0).
- Training: 2 updates with upd_index=4, upd_taken=1.
  - Counter goes 01->10->11; branch_predict=1 from the cycle after the first update.
  - A third taken update leaves it at 11 (saturation).
- Untraining:
  - From 11, two not-taken updates: prediction is still 1 after the first (10) and 0 after the second (01).
  - Further not-taken updates stop at 00.
- Same-cycle conflict:
  - upd_valid to index 4 together with a predict of index 4 returns the old value; the next cycle returns the new value.
  - upd_valid together with rst=1: counter reads 01 after the edge.
- Non-branch/target checks:
  - addu at any trained index gives branch_predict=0.
  - bne with imm=0xFFFF at pc=0x1000 gives addr=0x1000; bltzal decodes as a branch.
- GSHARE=1, GHR_BITS=2: updates taken,taken give ghr=2'b11.
  - pc=0x00000010 (pc bits=4) gives pred_index=7.
  - Reset returns ghr to 0 and pred_index to 4.
